// File: rtl/exe_stage.sv
// Execute-stage pipeline slot: holds one decoded bundle, drives the ALU, absorbs
// multi-cycle ALU stalls and hands the result to MEM over a valid/ready handshake.
module exe_stage #(
    parameter int unsigned ALU_OP_W = 19,
    parameter int unsigned DEST_W   = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,

    input  logic                ds_valid,
    output logic                ds_ready,
    input  logic [31:0]         ds_pc,
    input  logic [ALU_OP_W-1:0] ds_alu_op,
    input  logic [31:0]         ds_src1,
    input  logic [31:0]         ds_src2,
    input  logic [DEST_W-1:0]   ds_dest,
    input  logic                ds_gr_we,
    input  logic                ds_res_from_mem,
    input  logic                ds_mem_we,
    input  logic [31:0]         ds_st_data,

    output logic [ALU_OP_W-1:0] alu_op,
    output logic [31:0]         alu_src1,
    output logic [31:0]         alu_src2,
    input  logic [31:0]         alu_result,
    input  logic                alu_stall,

    output logic                es_to_ms_valid,
    input  logic                ms_ready,
    output logic [31:0]         es_pc,
    output logic [31:0]         es_result,
    output logic [DEST_W-1:0]   es_dest,
    output logic                es_gr_we,
    output logic                es_res_from_mem,
    output logic                es_mem_we,
    output logic [31:0]         es_st_data,

    output logic                fwd_valid,
    output logic [DEST_W-1:0]   fwd_dest,
    output logic [31:0]         fwd_data,
    output logic                fwd_block
);

    typedef enum logic [1:0] {
        StEmpty,
        StExec,
        StHold
    } state_e;

    state_e state_q, state_d;

    logic [31:0]         pc_q;
    logic [ALU_OP_W-1:0] op_q;
    logic [31:0]         src1_q;
    logic [31:0]         src2_q;
    logic [DEST_W-1:0]   dest_q;
    logic                gr_we_q;
    logic                res_from_mem_q;
    logic                mem_we_q;
    logic [31:0]         st_data_q;
    logic [31:0]         result_q;

    logic in_empty;
    logic in_exec;
    logic in_hold;
    logic exe_done;
    logic handoff;
    logic accept;

    always_comb begin
        in_empty = (state_q == StEmpty);
        in_exec  = (state_q == StExec);
        in_hold  = (state_q == StHold);
        exe_done = in_exec & ~alu_stall;

        es_to_ms_valid = rstn & ~flush & (exe_done | in_hold);
        handoff        = es_to_ms_valid & ms_ready;
        ds_ready       = (in_empty | handoff) & rstn & ~flush;
        accept         = ds_valid & ds_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (handoff) begin
                    state_d = accept ? StExec : StEmpty;
                end else if (exe_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (handoff) begin
                    state_d = accept ? StExec : StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush (and reset) abandon whatever is held, including an in-flight divide.
        if (!rstn || flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= StEmpty;
            pc_q           <= '0;
            op_q           <= '0;
            src1_q         <= '0;
            src2_q         <= '0;
            dest_q         <= '0;
            gr_we_q        <= 1'b0;
            res_from_mem_q <= 1'b0;
            mem_we_q       <= 1'b0;
            st_data_q      <= '0;
            result_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q           <= ds_pc;
                op_q           <= ds_alu_op;
                src1_q         <= ds_src1;
                src2_q         <= ds_src2;
                dest_q         <= ds_dest;
                gr_we_q        <= ds_gr_we;
                res_from_mem_q <= ds_res_from_mem;
                mem_we_q       <= ds_mem_we;
                st_data_q      <= ds_st_data;
            end
            if (exe_done && !flush) begin
                result_q <= alu_result;
            end
        end
    end

    // ALU op is gated by state only, so ms_ready never reaches the ALU combinationally.
    always_comb begin
        alu_op   = in_exec ? op_q : '0;
        alu_src1 = src1_q;
        alu_src2 = src2_q;
    end

    always_comb begin
        es_pc           = pc_q;
        es_result       = in_exec ? alu_result : result_q;
        es_dest         = dest_q;
        es_gr_we        = gr_we_q;
        es_res_from_mem = res_from_mem_q;
        es_mem_we       = mem_we_q;
        es_st_data      = st_data_q;
    end

    always_comb begin
        fwd_valid = ~in_empty & gr_we_q & (|dest_q);
        fwd_dest  = dest_q;
        fwd_data  = es_result;
        fwd_block = fwd_valid & (res_from_mem_q | (in_exec & alu_stall));
    end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized scoreboard bench for exe_stage: a stub ALU with programmable stall,
// a transaction-level occupancy model and a negedge monitor that checks every cycle.
module tb_exe_stage;

    localparam int unsigned ALU_OP_W = 19;
    localparam int unsigned DEST_W   = 5;

    logic                clk;
    logic                rstn;
    logic                flush;
    logic                ds_valid;
    logic                ds_ready;
    logic [31:0]         ds_pc;
    logic [ALU_OP_W-1:0] ds_alu_op;
    logic [31:0]         ds_src1;
    logic [31:0]         ds_src2;
    logic [DEST_W-1:0]   ds_dest;
    logic                ds_gr_we;
    logic                ds_res_from_mem;
    logic                ds_mem_we;
    logic [31:0]         ds_st_data;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         alu_src1;
    logic [31:0]         alu_src2;
    logic [31:0]         alu_result;
    logic                alu_stall;
    logic                es_to_ms_valid;
    logic                ms_ready;
    logic [31:0]         es_pc;
    logic [31:0]         es_result;
    logic [DEST_W-1:0]   es_dest;
    logic                es_gr_we;
    logic                es_res_from_mem;
    logic                es_mem_we;
    logic [31:0]         es_st_data;
    logic                fwd_valid;
    logic [DEST_W-1:0]   fwd_dest;
    logic [31:0]         fwd_data;
    logic                fwd_block;

    exe_stage #(
        .ALU_OP_W(ALU_OP_W),
        .DEST_W  (DEST_W)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .ds_valid       (ds_valid),
        .ds_ready       (ds_ready),
        .ds_pc          (ds_pc),
        .ds_alu_op      (ds_alu_op),
        .ds_src1        (ds_src1),
        .ds_src2        (ds_src2),
        .ds_dest        (ds_dest),
        .ds_gr_we       (ds_gr_we),
        .ds_res_from_mem(ds_res_from_mem),
        .ds_mem_we      (ds_mem_we),
        .ds_st_data     (ds_st_data),
        .alu_op         (alu_op),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .alu_result     (alu_result),
        .alu_stall      (alu_stall),
        .es_to_ms_valid (es_to_ms_valid),
        .ms_ready       (ms_ready),
        .es_pc          (es_pc),
        .es_result      (es_result),
        .es_dest        (es_dest),
        .es_gr_we       (es_gr_we),
        .es_res_from_mem(es_res_from_mem),
        .es_mem_we      (es_mem_we),
        .es_st_data     (es_st_data),
        .fwd_valid      (fwd_valid),
        .fwd_dest       (fwd_dest),
        .fwd_data       (fwd_data),
        .fwd_block      (fwd_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {KAdd, KSub, KAnd, KOr, KXor, KMul, KDiv, KNone} kind_e;

    typedef struct {
        logic [31:0]         pc;
        logic [ALU_OP_W-1:0] op;
        logic [31:0]         a;
        logic [31:0]         b;
        logic [DEST_W-1:0]   dest;
        logic                gr_we;
        logic                rfm;
        logic                mwe;
        logic [31:0]         st;
        logic [31:0]         res;
    } bundle_t;

    bundle_t exp_q[$];
    int      n_cmp = 0;
    int      n_err = 0;
    bit      started = 0;
    bit      occ = 0;
    bit      hold = 0;
    bit      rand_ready = 0;
    bit      rand_flush = 0;
    int      cur_stall = 0;
    int      stall_cnt = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Stub ALU decoding the one-hot op vector (bit0 add, 1 sub, 4 and, 6 or, 7 xor, 12 mul, 15 div).
    always_comb begin
        alu_result = 32'd0;
        if (alu_op[0])       alu_result = alu_src1 + alu_src2;
        else if (alu_op[1])  alu_result = alu_src1 - alu_src2;
        else if (alu_op[4])  alu_result = alu_src1 & alu_src2;
        else if (alu_op[6])  alu_result = alu_src1 | alu_src2;
        else if (alu_op[7])  alu_result = alu_src1 ^ alu_src2;
        else if (alu_op[12]) alu_result = alu_src1 * alu_src2;
        else if (alu_op[15] && alu_src2 != 32'd0)
            alu_result = 32'($signed(alu_src1) / $signed(alu_src2));
    end

    // Multi-cycle ALU latency: N stall cycles counted from the cycle the bundle is accepted.
    always @(posedge clk) begin
        if (!rstn || flush) stall_cnt <= 0;
        else if (ds_valid && ds_ready) stall_cnt <= cur_stall;
        else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    end
    assign alu_stall = (stall_cnt != 0);

    function automatic bundle_t make(input kind_e k, input logic [31:0] a, input logic [31:0] b,
                                     input logic [DEST_W-1:0] dest, input logic gr_we,
                                     input logic rfm, input logic mwe, input logic [31:0] st,
                                     input logic [31:0] pc);
        bundle_t r;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        r.pc = pc; r.a = a; r.b = b; r.dest = dest; r.gr_we = gr_we;
        r.rfm = rfm; r.mwe = mwe; r.st = st;
        r.op = '0;
        case (k)
            KAdd: begin r.op[0] = 1'b1;  r.res = a + b; end
            KSub: begin r.op[1] = 1'b1;  r.res = a - b; end
            KAnd: begin r.op[4] = 1'b1;  r.res = a & b; end
            KOr:  begin r.op[6] = 1'b1;  r.res = a | b; end
            KXor: begin r.op[7] = 1'b1;  r.res = a ^ b; end
            KMul: begin r.op[12] = 1'b1; r.res = 32'(a * b); end
            KDiv: begin r.op[15] = 1'b1; r.res = 32'(sa / sb); end
            default: r.res = 32'd0;
        endcase
        return r;
    endfunction

    task automatic send(input bundle_t b, input int stall);
        @(posedge clk);
        #1;
        ds_valid        = 1'b1;
        ds_pc           = b.pc;
        ds_alu_op       = b.op;
        ds_src1         = b.a;
        ds_src2         = b.b;
        ds_dest         = b.dest;
        ds_gr_we        = b.gr_we;
        ds_res_from_mem = b.rfm;
        ds_mem_we       = b.mwe;
        ds_st_data      = b.st;
        cur_stall       = stall;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ds_ready) begin
                exp_q.push_back(b);
                return;
            end
            @(posedge clk);
            #1;
        end
        fail_now("send_accept");
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        ds_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!occ && exp_q.size() == 0) return;
        end
        fail_now("drain");
    endtask

    // Monitor: compares every cycle against the occupancy model, pops the scoreboard on handoff.
    always @(negedge clk) begin
        bundle_t f;
        logic ev, er, fv, fb;
        logic [ALU_OP_W-1:0] eop;
        if (started) begin
            f = '{default: '0};
            if (exp_q.size() > 0) f = exp_q[0];
            if (occ && exp_q.size() == 0) fail_now("scoreboard_empty");
            ev = rstn & ~flush & occ & ~alu_stall;
            er = rstn & ~flush & (~occ | (ev & ms_ready));
            check1("es_to_ms_valid", es_to_ms_valid, ev);
            check1("ds_ready", ds_ready, er);
            eop = (occ && !hold) ? f.op : '0;
            check32("alu_op", 32'(alu_op), 32'(eop));
            if (eop != '0) begin
                check32("alu_src1", alu_src1, f.a);
                check32("alu_src2", alu_src2, f.b);
            end
            fv = occ & f.gr_we & (f.dest != '0);
            fb = fv & (f.rfm | alu_stall);
            check1("fwd_valid", fwd_valid, fv);
            check1("fwd_block", fwd_block, fb);
            if (occ) check32("fwd_dest", 32'(fwd_dest), 32'(f.dest));
            if (occ && !alu_stall) begin
                check32("es_result", es_result, f.res);
                check32("fwd_data", fwd_data, f.res);
            end
            if (!rstn || flush) begin
                if (occ && exp_q.size() > 0) void'(exp_q.pop_front());
                occ  = 1'b0;
                hold = 1'b0;
            end else begin
                if (ev && ms_ready) begin
                    check32("hand_pc", es_pc, f.pc);
                    check32("hand_ctl", {24'd0, es_dest, es_gr_we, es_res_from_mem, es_mem_we},
                            {24'd0, f.dest, f.gr_we, f.rfm, f.mwe});
                    check32("hand_st_data", es_st_data, f.st);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    occ  = 1'b0;
                    hold = 1'b0;
                end else if (ev) begin
                    hold = 1'b1;
                end
                if (ds_valid && er) occ = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) ms_ready = ($urandom % 4) != 0;
            if (rand_flush) flush = ($urandom % 40) == 0;
        end
    end

    task automatic check_cleared(input string tag);
        check32({tag, "_es_pc"}, es_pc, 32'd0);
        check32({tag, "_es_result"}, es_result, 32'd0);
        check32({tag, "_es_st_data"}, es_st_data, 32'd0);
        check32({tag, "_es_ctl"}, {24'd0, es_dest, es_gr_we, es_res_from_mem, es_mem_we}, 32'd0);
        check32({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check32({tag, "_alu_src"}, alu_src1 | alu_src2, 32'd0);
        check1({tag, "_valid"}, es_to_ms_valid, 1'b0);
        check1({tag, "_fwd_valid"}, fwd_valid, 1'b0);
    endtask

    initial begin
        bundle_t b;
        kind_e   k;
        int      st;
        rstn = 1'b0; flush = 1'b0; ds_valid = 1'b0; ms_ready = 1'b0;
        ds_pc = '0; ds_alu_op = '0; ds_src1 = '0; ds_src2 = '0; ds_dest = '0;
        ds_gr_we = 1'b0; ds_res_from_mem = 1'b0; ds_mem_we = 1'b0; ds_st_data = '0;

        @(posedge clk);
        started = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        check1("reset_ds_ready", ds_ready, 1'b0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single add.
        ms_ready = 1'b1;
        send(make(KAdd, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1c00_0000), 0);
        idle();
        drain();

        // Mul with MEM backpressure; stays in HOLD with the ALU idle.
        ms_ready = 1'b0;
        send(make(KMul, 32'd6, 32'd7, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1c00_0004), 1);
        idle();
        repeat (4) @(posedge clk);
        #1 ms_ready = 1'b1;
        drain();

        // Back-to-back adds.
        for (int i = 1; i <= 3; i++) begin
            send(make(KAdd, 32'(i), 32'(i), 5'(i + 10), 1'b1, 1'b0, 1'b0, 32'd0,
                      32'h1c00_0100 + 32'(4 * i)), 0);
        end
        idle();
        drain();

        // Flush during a divide stall, then a normal add.
        send(make(KDiv, 32'd100, 32'd7, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1c00_0200), 5);
        idle();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        send(make(KAdd, 32'd1, 32'd2, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1c00_0204), 0);
        idle();
        drain();

        // Forwarding: load, write to r0, plain add.
        send(make(KAdd, 32'h100, 32'h8, 5'd4, 1'b1, 1'b1, 1'b0, 32'd0, 32'h1c00_0300), 0);
        send(make(KAdd, 32'd3, 32'd4, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1c00_0304), 0);
        send(make(KAdd, 32'd10, 32'd20, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1c00_0308), 0);
        idle();
        drain();

        // Reset while holding a result.
        ms_ready = 1'b0;
        send(make(KMul, 32'd6, 32'd7, 5'd8, 1'b1, 1'b0, 1'b1, 32'hdead_beef, 32'h1c00_0400), 1);
        idle();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_cleared("midhold_reset");
        ms_ready = 1'b1;
        drain();

        // Randomized traffic with random backpressure and flushes.
        rand_ready = 1'b1;
        rand_flush = 1'b1;
        for (int n = 0; n < 300; n++) begin
            k  = kind_e'($urandom % 8);
            b  = make(k, $urandom, (k == KDiv) ? 32'($urandom_range(1, 1000)) : $urandom,
                      5'($urandom % 32), 1'($urandom % 2), 1'(($urandom % 4) == 0),
                      1'(($urandom % 4) == 0), $urandom, $urandom & ~32'd3);
            st = (k == KMul || k == KDiv) ? int'($urandom_range(0, 4)) : 0;
            send(b, st);
            if (($urandom % 3) == 0) begin
                idle();
                repeat ($urandom % 3) @(posedge clk);
            end
        end
        idle();
        rand_ready = 1'b0;
        rand_flush = 1'b0;
        @(posedge clk);
        #1;
        ms_ready = 1'b1;
        flush    = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute-stage pipeline slot of the scalar LoongArch core, between decode (ds_*) and memory (ms_*).
- Holds one decoded instruction bundle and drives the ALU's operation and operand inputs.
- Absorbs ALU multi-cycle stalls (mul/div) and captures the ALU result. Hands the result to MEM with a valid/ready handshake.
- Exports a forwarding/interlock port back to decode. Supports synchronous pipeline flush.

Parameters:
ALU_OP_W, 19, width of one-hot ALU operation vector (bit0 add … bit18 modu)
DEST_W, 5, register-file destination index width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
flush  in  1  kill the held instruction (exception/branch redirect)
ds_valid  in  1  decode offers a bundle
ds_ready  out  1  exe accepts a bundle this cycle
ds_pc  in  32  instruction PC
ds_alu_op  in  ALU_OP_W  one-hot ALU operation (all-zero = no ALU op)
ds_src1  in  32  ALU operand 1
ds_src2  in  32  ALU operand 2
ds_dest  in  DEST_W  destination register
ds_gr_we  in  1  register write enable
ds_res_from_mem  in  1  load: writeback data comes from memory
ds_mem_we  in  1  store
ds_st_data  in  32  store data
alu_op  out  ALU_OP_W  to ALU
alu_src1  out  32  to ALU
alu_src2  out  32  to ALU
alu_result  in  32  from ALU (combinational on alu_op/srcs)
alu_stall  in  1  ALU result not yet valid
es_to_ms_valid  out  1  result offered to MEM
ms_ready  in  1  MEM accepts
es_pc  out  32  held PC
es_result  out  32  ALU result / memory address
es_dest  out  DEST_W  held dest
es_gr_we  out  1  held write enable
es_res_from_mem  out  1  held load flag
es_mem_we  out  1  held store flag
es_st_data  out  32  held store data
fwd_valid  out  1  exe holds a register-writing instr with dest≠0
fwd_dest  out  DEST_W  = es_dest
fwd_data  out  32  = es_result
fwd_block  out  1  forwarded data not usable yet; decode must stall on match

Behaviour:
- Reset (rstn=0 at posedge): state=EMPTY; all bundle registers and the result register cleared to 0.
  - While rstn=0 and in EMPTY: ds_ready=0, es_to_ms_valid=0, alu_op=0, fwd_valid=0, fwd_block=0.
- States: EMPTY, EXEC, HOLD.
  - EMPTY: alu_op=0; ds_ready=1 (if rstn=1, flush=0). ds_valid&ds_ready → latch bundle, go to EXEC.
  - EXEC: alu_op/src1/src2 driven from the held bundle, constant for the whole stay.
    - alu_stall=1 → stay; es_to_ms_valid=0.
    - alu_stall=0 → es_to_ms_valid=1, es_result=alu_result.
      - If ms_ready: handoff.
      - If !ms_ready: latch alu_result into result reg, go to HOLD.
  - HOLD: alu_op=0, so the ALU multiplier does not re-issue. es_to_ms_valid=1, es_result=result reg; waits for ms_ready → handoff.
- Handoff (es_to_ms_valid&ms_ready): ds_ready=1 in the same cycle.
  - ds_valid=1 → load new bundle, go to EXEC (back-to-back, zero bubble).
  - Otherwise → EMPTY.
- ds_ready = (state==EMPTY | handoff) & rstn & ~flush.
- Flush (synchronous, highest priority after reset):
  - In the flush cycle: es_to_ms_valid=0, ds_ready=0, no handoff.
  - Next state is EMPTY from any state, including EXEC mid-divide. An in-flight ALU divide is abandoned: alu_op=0 from the next cycle.
- Reset mid-operation behaves as flush, plus register clearing.
- Results with alu_op=0 (none one-hot) pass alu_result unchanged; the ALU returns 0.
- Forwarding:
  - fwd_valid = (state≠EMPTY) & es_gr_we & (es_dest≠0).
  - fwd_block = fwd_valid & (es_res_from_mem | (state==EXEC & alu_stall)).
  - fwd_data = es_result.
- es_* bundle outputs are register-driven. es_result is muxed: alu_result in EXEC, result reg in HOLD.
- No combinational path from ms_ready to alu_op.

Test Plan:
1. Single add: ds op=add, src1=5, src2=7, dest=3, ms_ready=1 → es_to_ms_valid=1 one cycle after accept, es_result=12, ds_ready=1 that cycle.
2. Mul with MEM backpressure: op=mul, 6×7, alu_stall=1 for 1 cycle, ms_ready=0 for 3 cycles → enters HOLD with alu_op=0; es_result=42 held stable; handoff on the first cycle ms_ready=1.
3. Back-to-back: three add bundles (1+1, 2+2, 3+3), ds_valid and ms_ready held 1 → results 2, 4, 6 on consecutive cycles, no bubbles.
4. Flush during div stall: op=div 100/7, flush while alu_stall=1 → no es_to_ms_valid; state EMPTY and ds_ready=1 the next cycle; following add 1+2 → 3.
5. Forwarding/interlock: load bundle dest=4 → fwd_valid=1, fwd_block=1. Add dest=0 → fwd_valid=0. Add dest=9, 10+20 → fwd_data=30, fwd_block=0.
6. Reset mid-HOLD: result 42 held, rstn=0 one cycle → all outputs 0, state EMPTY; ds_ready=1 once rstn=1.
